// File: rtl/conv_row_window.sv
// conv_row_window: row-at-a-time feeder producing packed 3x3 windows
// for three channels, with a two-row line buffer per channel.
// Ports: clk, rst_n (async, active-low); row_vld_i/row_rdy_o with
// row0_i..row2_i (one image row per channel); win_vld_o/win_rdy_i with
// x0_o..x2_o (OUT_W packed windows), row_idx_o, frame_last_o;
// stall_cnt_o counts backpressure cycles when CONV_ROW_WIN_STALL_CNT_EN
// is defined, otherwise it is tied to 0.
module conv_row_window #(
   parameter int DAT_W = 8,
   parameter int PIC_W = 48,
   parameter int PIC_H = 48
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             row_vld_i,
   output logic                             row_rdy_o,
   input  logic [PIC_W*DAT_W-1:0]           row0_i,
   input  logic [PIC_W*DAT_W-1:0]           row1_i,
   input  logic [PIC_W*DAT_W-1:0]           row2_i,
   output logic                             win_vld_o,
   input  logic                             win_rdy_i,
   output logic [(PIC_W-2)*9*DAT_W-1:0]     x0_o,
   output logic [(PIC_W-2)*9*DAT_W-1:0]     x1_o,
   output logic [(PIC_W-2)*9*DAT_W-1:0]     x2_o,
   output logic [5:0]                       row_idx_o,
   output logic                             frame_last_o,
   output logic [15:0]                      stall_cnt_o
);

   localparam int OUT_W = PIC_W - 2;
   localparam int ROW_W = PIC_W * DAT_W;
   localparam int WIN_W = 9 * DAT_W;
   localparam int SEG_W = 3 * DAT_W;
   localparam logic [5:0] LAST_ROW = 6'(PIC_H - 1);

   typedef enum logic {FILL, STREAM} state_e;

   state_e state_q, state_d;
   logic [5:0] in_row_q, in_row_d;
   logic [2:0][ROW_W-1:0] row_w;
   logic [2:0][ROW_W-1:0] lold_q, lold_d;
   logic [2:0][ROW_W-1:0] lnew_q, lnew_d;
   logic [2:0][ROW_W-1:0] top_q, top_d;
   logic [2:0][ROW_W-1:0] mid_q, mid_d;
   logic [2:0][ROW_W-1:0] bot_q, bot_d;
   logic win_vld_q, win_vld_d;
   logic [5:0] row_idx_q, row_idx_d;
   logic last_q, last_d;
   logic row_acc, win_xfer;
   logic [2:0][OUT_W*WIN_W-1:0] x_w;

   assign row_w = {row2_i, row1_i, row0_i};

   // FILL never waits on the output side, so a new frame can start
   // while the last window of the previous frame is still pending.
   assign row_rdy_o = (state_q == FILL) || !win_vld_q || win_rdy_i;
   assign row_acc   = row_vld_i && row_rdy_o;
   assign win_xfer  = win_vld_q && win_rdy_i;

   always_comb begin
      state_d   = state_q;
      in_row_d  = in_row_q;
      lold_d    = lold_q;
      lnew_d    = lnew_q;
      top_d     = top_q;
      mid_d     = mid_q;
      bot_d     = bot_q;
      win_vld_d = win_vld_q;
      row_idx_d = row_idx_q;
      last_d    = last_q;

      if (win_xfer) begin
         win_vld_d = 1'b0;
      end

      if (row_acc) begin
         in_row_d = (in_row_q == LAST_ROW) ? 6'd0 : in_row_q + 6'd1;
         lold_d   = lnew_q;
         lnew_d   = row_w;
         unique case (state_q)
            FILL: begin
            end
            STREAM: begin
               top_d     = lold_q;
               mid_d     = lnew_q;
               bot_d     = row_w;
               row_idx_d = in_row_q - 6'd2;
               last_d    = (in_row_q == LAST_ROW);
               win_vld_d = 1'b1;
            end
            default: begin
            end
         endcase
      end

      state_d = (in_row_d >= 6'd2) ? STREAM : FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         in_row_q  <= '0;
         lold_q    <= '0;
         lnew_q    <= '0;
         top_q     <= '0;
         mid_q     <= '0;
         bot_q     <= '0;
         win_vld_q <= 1'b0;
         row_idx_q <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_row_q  <= in_row_d;
         lold_q    <= lold_d;
         lnew_q    <= lnew_d;
         top_q     <= top_d;
         mid_q     <= mid_d;
         bot_q     <= bot_d;
         win_vld_q <= win_vld_d;
         row_idx_q <= row_idx_d;
         last_q    <= last_d;
      end
   end

   // Window j: three pixels j..j+2 from each of top, mid, bot,
   // top in the most significant third.
   for (genvar c = 0; c < 3; c++) begin : g_ch
      for (genvar j = 0; j < OUT_W; j++) begin : g_win
         assign x_w[c][WIN_W*j +: WIN_W] = {
            top_q[c][DAT_W*j +: SEG_W],
            mid_q[c][DAT_W*j +: SEG_W],
            bot_q[c][DAT_W*j +: SEG_W]};
      end
   end

   assign x0_o         = x_w[0];
   assign x1_o         = x_w[1];
   assign x2_o         = x_w[2];
   assign win_vld_o    = win_vld_q;
   assign row_idx_o    = row_idx_q;
   assign frame_last_o = last_q;

`ifdef CONV_ROW_WIN_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Row 0 of a frame restarts the count, even if that cycle stalls.
   always_comb begin
      stall_d = stall_q;
      if (row_acc && (in_row_q == 6'd0)) begin
         stall_d = '0;
      end else if (win_vld_q && !win_rdy_i && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_conv_row_window.sv
// tb_conv_row_window: directed and table-driven checks of conv_row_window
// against a pixel-formula scoreboard.
module tb_conv_row_window;

   localparam int PW = 48;
   localparam int PH = 48;
   localparam int OW = PW - 2;
   localparam int RW = PW * 8;
   localparam int XW = OW * 72;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic row_vld_i = 1'b0;
   logic row_rdy_o;
   logic [RW-1:0] row0_i = '0;
   logic [RW-1:0] row1_i = '0;
   logic [RW-1:0] row2_i = '0;
   logic win_vld_o;
   logic win_rdy_i = 1'b1;
   logic [XW-1:0] x0_o, x1_o, x2_o;
   logic [5:0] row_idx_o;
   logic frame_last_o;
   logic [15:0] stall_cnt_o;

   conv_row_window dut (
      .clk(clk), .rst_n(rst_n),
      .row_vld_i(row_vld_i), .row_rdy_o(row_rdy_o),
      .row0_i(row0_i), .row1_i(row1_i), .row2_i(row2_i),
      .win_vld_o(win_vld_o), .win_rdy_i(win_rdy_i),
      .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o),
      .row_idx_o(row_idx_o), .frame_last_o(frame_last_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int win_cnt = 0;
   int cur_tag = 0;
   int rdy_mode = 0;
   bit cap_en = 0;
   bit first_after_rst = 0;
   logic [XW-1:0] cap [0:OW-1][0:2];

   typedef struct {
      int tag;
      int r;
   } exp_t;
   exp_t q[$];
   int m_in_row = 0;

   bit prev_hold = 0;
   logic [XW-1:0] h_x0, h_x1, h_x2;
   logic [5:0] h_idx;
   logic h_last;

   typedef struct {
      int r;
      int j;
      int ch;
      logic [71:0] exp;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int tag, input int r,
                                      input int c, input int ch);
      logic [7:0] v;
      v = 8'((r * PW + c + ch) & 255);
      return (tag != 0) ? ~v : v;
   endfunction

   function automatic logic [RW-1:0] mkrow(input int tag, input int r,
                                           input int ch);
      logic [RW-1:0] v;
      for (int c = 0; c < PW; c++) v[8*c +: 8] = pix(tag, r, c, ch);
      return v;
   endfunction

   function automatic logic [XW-1:0] build_x(input int tag, input int r,
                                             input int ch);
      logic [XW-1:0] v;
      for (int j = 0; j < OW; j++)
         for (int k = 0; k < 3; k++)
            for (int m = 0; m < 3; m++)
               v[72*j + 24*(2-k) + 8*m +: 8] = pix(tag, r + k, j + m, ch);
      return v;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) win_rdy_i = 1'b1;
      else if (rdy_mode == 1) win_rdy_i = 1'($urandom % 2);
   end

   // Monitor: inputs change just after posedge, so values seen here
   // are exactly what the next posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_in_row = 0;
         prev_hold = 0;
         first_after_rst = 1;
      end else begin
         if (prev_hold) begin
            checks++;
            if (x0_o !== h_x0 || x1_o !== h_x1 || x2_o !== h_x2 ||
                row_idx_o !== h_idx || frame_last_o !== h_last ||
                win_vld_o !== 1'b1) begin
               errors++;
               $display("FAIL hold idx act=%0d exp=%0d", row_idx_o, h_idx);
            end
         end
         prev_hold = win_vld_o && !win_rdy_i;
         h_x0 = x0_o; h_x1 = x1_o; h_x2 = x2_o;
         h_idx = row_idx_o; h_last = frame_last_o;

         if (win_vld_o && win_rdy_i) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_win idx act=%0d exp=none", row_idx_o);
            end else begin
               exp_t e;
               logic [XW-1:0] xa [3];
               logic [XW-1:0] xe;
               bit bad;
               e = q.pop_front();
               xa[0] = x0_o; xa[1] = x1_o; xa[2] = x2_o;
               bad = (row_idx_o != 6'(e.r)) ||
                     (frame_last_o != (e.r == PH - 3));
               for (int c = 0; c < 3; c++) begin
                  xe = build_x(e.tag, e.r, c);
                  if (xa[c] !== xe) begin
                     bad = 1;
                     $display("FAIL win tag=%0d r=%0d ch%0d act=%h exp=%h",
                              e.tag, e.r, c, xa[c][63:0], xe[63:0]);
                  end
                  if (cap_en) cap[e.r][c] = xa[c];
               end
               if (bad) begin
                  errors++;
                  $display("FAIL win_hdr idx act=%0d exp=%0d last act=%0d",
                           row_idx_o, e.r, frame_last_o);
               end
               if (first_after_rst) begin
                  checks++;
                  if (row_idx_o != 6'd0) begin
                     errors++;
                     $display("FAIL first_idx act=%0d exp=0", row_idx_o);
                  end
                  first_after_rst = 0;
               end
               win_cnt++;
            end
         end

         if (row_vld_i && row_rdy_o) begin
            if (m_in_row >= 2) q.push_back('{cur_tag, m_in_row - 2});
            m_in_row = (m_in_row == PH - 1) ? 0 : m_in_row + 1;
         end
      end
   end

   task automatic send_rows(input int tag, input int nrows, input bit rnd);
      for (int r = 0; r < nrows; r++) begin
         int guard;
         bit done;
         guard = 0;
         done = 0;
         cur_tag = tag;
         row0_i = mkrow(tag, r, 0);
         row1_i = mkrow(tag, r, 1);
         row2_i = mkrow(tag, r, 2);
         while (!done) begin
            row_vld_i = rnd ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            done = row_vld_i && row_rdy_o;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 2000) begin
               chk("row_timeout", r, -1);
               done = 1;
            end
         end
      end
      row_vld_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((win_vld_o || q.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", n, 0);
   endtask

   initial begin
      tbl[0] = '{0,  0,  0, 72'h020100_323130_626160};
      tbl[1] = '{0,  0,  2, 72'h040302_343332_646362};
      tbl[2] = '{45, 45, 0, 72'h9F9E9D_CFCECD_FFFEFD};
      tbl[3] = '{45, 45, 1, 72'hA09F9E_D0CFCE_00FFFE};
      tbl[4] = '{10, 20, 0, 72'hF6F5F4_262524_565554};
      tbl[5] = '{5,  0,  1, 72'hF3F2F1_232221_535251};

      #12;
      chk("rst_rdy", row_rdy_o, 1);
      chk("rst_vld", win_vld_o, 0);
      chk("rst_idx", row_idx_o, 0);
      chk("rst_last", frame_last_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      chk("rst_x0", |x0_o, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Ramp frame, full throughput, captured for the vector table
      cap_en = 1;
      win_cnt = 0;
      send_rows(0, PH, 0);
      drain();
      cap_en = 0;
      chk("wins_ramp", win_cnt, 46);
      for (int i = 0; i < 6; i++) begin
         logic [71:0] got;
         got = cap[tbl[i].r][tbl[i].ch][72*tbl[i].j +: 72];
         checks++;
         if (got !== tbl[i].exp) begin
            errors++;
            $display("FAIL tbl%0d act=%h exp=%h", i, got, tbl[i].exp);
         end
      end

      // Five-cycle stall right after the first window
      win_cnt = 0;
      rdy_mode = 2;
      win_rdy_i = 1'b0;
      fork
         send_rows(0, PH, 0);
         begin
            int n;
            n = 0;
            while (!win_vld_o && n < 100) begin
               @(posedge clk);
               #1;
               n++;
            end
            chk("stall_vld", win_vld_o, 1);
            for (int k = 0; k < 5; k++) begin
               chk("stall_rdy", row_rdy_o, 0);
               @(posedge clk);
               #1;
            end
            win_rdy_i = 1'b1;
`ifdef CONV_ROW_WIN_STALL_CNT_EN
            chk("stall_cnt", stall_cnt_o, 5);
`else
            chk("stall_cnt", stall_cnt_o, 0);
`endif
            rdy_mode = 0;
         end
      join
      drain();
      chk("wins_stall", win_cnt, 46);

      // Two frames back to back, the second inverted
      win_cnt = 0;
      send_rows(0, PH, 0);
      send_rows(1, PH, 0);
      drain();
      chk("wins_2frm", win_cnt, 92);

      // Random gaps on both sides over three frames
      win_cnt = 0;
      rdy_mode = 1;
      send_rows(0, PH, 1);
      send_rows(1, PH, 1);
      send_rows(0, PH, 1);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      drain();
      chk("wins_rand", win_cnt, 138);

      // Reset in mid-frame with a window pending
      rdy_mode = 2;
      win_rdy_i = 1'b1;
      send_rows(0, 20, 0);
      win_rdy_i = 1'b0;
      chk("pend_vld", win_vld_o, 1);
      chk("pend_idx", row_idx_o, 17);
      rst_n = 1'b0;
      #1;
      chk("mrst_vld", win_vld_o, 0);
      chk("mrst_rdy", row_rdy_o, 1);
      chk("mrst_idx", row_idx_o, 0);
      chk("mrst_stall", stall_cnt_o, 0);
      chk("mrst_x1", |x1_o, 0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      win_rdy_i = 1'b1;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      win_cnt = 0;
      send_rows(0, PH, 0);
      drain();
      chk("wins_after_rst", win_cnt, 46);
      chk("first_seen", first_after_rst, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
